spin_rng_arbiter: RTL and testbench
===================================

SPIN_RNG_ARBITER -- requirements
Module: spin_rng_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter RAND_W, default 12, SHALL set the delivered random word width.
REQ-003 Parameter SEED_INIT, default 16'hACE1, SHALL set the LFSR reset/fallback seed.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 req  in  N_REQ  SHALL carry per-requester random-word requests, level, held until gnt.
REQ-007 gnt  out  N_REQ  SHALL be a one-hot, one-cycle grant that marks the owner of rand_out.
REQ-008 rand_out  out  RAND_W  SHALL carry the delivered random word, valid only when rand_valid=1.
REQ-009 rand_valid  out  1  SHALL pulse high for exactly the cycle gnt is non-zero.
REQ-010 busy  out  1  SHALL be high in every state except IDLE.
REQ-011 seed_load  in  1, seed_val  in  16  SHALL request an LFSR reseed (present only with RNG_RESEED_EN).

Function
REQ-012 State machine SHALL have states IDLE, GEN, DELIVER; IDLE->GEN when any req bit is set; GEN->DELIVER after RAND_W steps; DELIVER->IDLE unconditionally.
REQ-013 Arbitration SHALL be round-robin: in IDLE, pick the first set req bit searching upward (with wrap) from last_owner+1; last_owner resets to N_REQ-1, so req[0] wins first.
REQ-014 Owner SHALL be latched on the IDLE->GEN edge; later req changes SHALL NOT alter the owner or abort the transaction; owner updates last_owner in DELIVER.
REQ-015 LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11: out bit = s[15], fb = s[15]^s[13]^s[12]^s[10], next s = {s[14:0], fb}.
REQ-016 In GEN, each cycle j (0..RAND_W-1) SHALL step the LFSR once and shift out bit into rand_out bit j (bit 0 = first bit).
REQ-017 LFSR state SHALL persist across transactions and SHALL step only in GEN.
REQ-018 Latency: req seen in IDLE at edge k -> gnt/rand_valid high in cycle k+1+RAND_W; one transaction = RAND_W+2 cycles.
REQ-019 rand_out SHALL hold its last delivered value outside DELIVER; gnt SHALL be zero outside DELIVER.
REQ-020 req=0 in IDLE SHALL keep the block in IDLE with the LFSR frozen.

Reset
REQ-021 rst high SHALL immediately force: state=IDLE, gnt=0, rand_valid=0, busy=0, rand_out=0, LFSR=SEED_INIT, last_owner=N_REQ-1.
REQ-022 Reset asserted mid-GEN or mid-DELIVER SHALL abandon the transaction with no grant issued.

Configuration
REQ-023 Macro RNG_RESEED_EN defined: seed_load/seed_val ports exist; seed_load=1 in IDLE loads seed_val (SEED_INIT if seed_val==0) and takes priority over req that cycle (req stays pending); seed_load outside IDLE SHALL be ignored.
REQ-024 Macro RNG_RESEED_EN undefined: ports absent; LFSR is seeded only by reset.

Structure
REQ-025 Package spin_rng_pkg SHALL hold the state enum, SEED_INIT default, LFSR width (16) and tap constants.
REQ-026 LFSR SHALL be a sub-module spin_lfsr16 (inputs step, load, load_val; outputs state, out_bit).

Verification
REQ-027 Reset, req=4'b0001 held -> gnt=4'b0001 with rand_out=12'h735 at cycle 13 after request; next request -> rand_out=12'h278.
REQ-028 req=4'b1111 held -> grants in order 0001,0010,0100,1000,0001, spaced 14 cycles.
REQ-029 req=4'b0101 after reset, then req[0] dropped during GEN -> gnt=4'b0001 still issued; next grant to req[2].
REQ-030 rst pulsed during GEN cycle 5 -> no gnt; outputs zero; next transaction yields 12'h735.
REQ-031 (RNG_RESEED_EN) seed_load with seed_val=16'hFFFF in IDLE, then req[1] -> rand_out=12'hFFF; seed_val=0 reload then request -> 12'h735.
REQ-032 seed_load and req[0] asserted in the same IDLE cycle -> reseed first, grant follows one cycle later than REQ-018.

Source files
------------

// File: rtl/spin_rng_pkg.sv
// Shared types and constants for the round-robin random-word arbiter:
// FSM state encoding, LFSR geometry/taps and the default seed.
package spin_rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GEN     = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] SEED_INIT_DEF = 16'hACE1;

  // x^16 + x^14 + x^13 + x^11 expressed as state bit positions
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/spin_lfsr16.sv
// 16-bit Fibonacci LFSR shifting left; out_bit is the MSB about to leave.
// load has priority over step.
module spin_lfsr16
  import spin_rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_INIT = SEED_INIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state,
  output logic              out_bit
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_INIT;
    end else if (load) begin
      r_state <= load_val;
    end else if (step) begin
      r_state <= {r_state[LFSR_W-2:0], lfsr_fb(r_state)};
    end
  end

  assign state   = r_state;
  assign out_bit = r_state[LFSR_W-1];

endmodule

// File: rtl/spin_rng_arbiter.sv
// Round-robin arbiter handing out RAND_W-bit words built serially from a shared LFSR.
// Optional runtime reseed port enabled by defining RNG_RESEED_EN.
module spin_rng_arbiter
  import spin_rng_pkg::*;
#(
  parameter int                N_REQ     = 4,
  parameter int                RAND_W    = 12,
  parameter logic [LFSR_W-1:0] SEED_INIT = SEED_INIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RNG_RESEED_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
`endif
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [RAND_W-1:0] rand_out,
  output logic              rand_valid,
  output logic              busy
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RAND_W + 1);
  localparam logic [OW-1:0] LAST_RST = OW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RAND_W - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  logic [OW-1:0]       r_last_owner, r_owner, w_pick, w_cand;
  logic [CW-1:0]       r_cnt;
  logic [RAND_W-1:0]   r_acc, r_rand_out;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_rand_valid;
  logic                w_step, w_load, w_out_bit, w_lock;
  logic                w_seed_load;
  logic [LFSR_W-1:0]   w_seed_val, w_load_val, w_lfsr_state;

`ifdef RNG_RESEED_EN
  assign w_seed_load = seed_load;
  assign w_seed_val  = seed_val;
`else
  assign w_seed_load = 1'b0;
  assign w_seed_val  = '0;
`endif

  // An all-zero seed would lock the LFSR, so it falls back to SEED_INIT.
  assign w_load_val = (w_seed_load && (w_seed_val != '0)) ? w_seed_val : SEED_INIT;
  assign w_lock     = (w_lfsr_state == '0);

  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[OW-1:0];
  endfunction

  // Walk downward so the nearest requester after last_owner is the final winner.
  always_comb begin
    w_pick = r_last_owner;
    w_cand = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_cand = wrap_idx(r_last_owner, i);
      if (req[w_cand]) w_pick = w_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_load      = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_seed_load || w_lock) begin
          w_load = 1'b1;
        end else if (|req) begin
          w_state_nxt = ST_GEN;
        end
      end
      ST_GEN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_DELIVER;
      end
      ST_DELIVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  spin_lfsr16 #(
    .SEED_INIT (SEED_INIT)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (w_step),
    .load     (w_load),
    .load_val (w_load_val),
    .state    (w_lfsr_state),
    .out_bit  (w_out_bit)
  );

  // First generated bit lands in bit 0 after RAND_W right shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= LAST_RST;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_rand_out   <= '0;
      r_gnt        <= '0;
      r_rand_valid <= 1'b0;
    end else begin
      r_gnt        <= '0;
      r_rand_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_state_nxt == ST_GEN) r_owner <= w_pick;
        end
        ST_GEN: begin
          r_acc <= {w_out_bit, r_acc[RAND_W-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_rand_out   <= {w_out_bit, r_acc[RAND_W-1:1]};
            r_gnt        <= ONE_HOT0 << r_owner;
            r_rand_valid <= 1'b1;
          end
        end
        ST_DELIVER: r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rand_out   = r_rand_out;
  assign rand_valid = r_rand_valid;

endmodule

// File: tb/tb_spin_rng_arbiter.sv
// Directed self-checking bench for spin_rng_arbiter (reseed cases need RNG_RESEED_EN).
module tb_spin_rng_arbiter;

  localparam int N = 4;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_load = 1'b0;
  logic [15:0]  seed_val = 16'h0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [W-1:0] rand_out;
  logic         rand_valid;
  logic         busy;

  int errors = 0;
  int checks = 0;

  spin_rng_arbiter #(.N_REQ(N), .RAND_W(W), .SEED_INIT(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RNG_RESEED_EN
    .seed_load  (seed_load),
    .seed_val   (seed_val),
`endif
    .req        (req),
    .gnt        (gnt),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // rand_valid must track a non-zero one-hot grant every cycle
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((rand_valid !== (gnt != '0)) || ($countones(gnt) > 1)) begin
        errors++;
        $display("FAIL valid_pairing: gnt=%b rand_valid=%b", gnt, rand_valid);
      end
    end
  end

  task automatic wait_gnt(input int max_cyc, output int cyc, output logic [N-1:0] g,
                          output logic [W-1:0] r, output logic rv);
    cyc = -1; g = '0; r = '0; rv = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      if (gnt !== '0) begin
        cyc = c; g = gnt; r = rand_out; rv = rand_valid;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req = '0; seed_load = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 4'b0000 || rand_valid !== 1'b0 || busy !== 1'b0 || rand_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b rv=%b busy=%b rand_out=%h required 0000/0/0/000",
               gnt, rand_valid, busy, rand_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int cyc; logic [N-1:0] g; logic [W-1:0] r; logic rv;
    do_reset();
    req = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b required 1", busy); end
    wait_gnt(40, cyc, g, r, rv);
    cyc = cyc + 1;
    checks++;
    if (cyc !== 13 || g !== 4'b0001 || r !== 12'h735 || rv !== 1'b1) begin
      errors++;
      $display("FAIL single_first: cyc=%0d gnt=%b rand=%h rv=%b required 13/0001/735/1", cyc, g, r, rv);
    end
    req = '0;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 4'b0000 || rand_out !== 12'h735 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: gnt=%b rand=%h busy=%b required 0000/735/0", gnt, rand_out, busy);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (rand_out !== 12'h735 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_freeze: rand=%h busy=%b required 735/0", rand_out, busy);
    end
    req = 4'b0001;
    wait_gnt(40, cyc, g, r, rv);
    checks++;
    if (cyc !== 13 || g !== 4'b0001 || r !== 12'h278) begin
      errors++;
      $display("FAIL single_second: cyc=%0d gnt=%b rand=%h required 13/0001/278", cyc, g, r);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int cyc; logic [N-1:0] g; logic [W-1:0] r; logic rv;
    logic [N-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(40, cyc, g, r, rv);
      checks++;
      if (g !== exp_g[k] || cyc !== ((k == 0) ? 13 : 14)) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b cyc=%0d required %b/%0d", k, g, cyc, exp_g[k],
                 (k == 0) ? 13 : 14);
      end
    end
    req = '0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_drop_during_gen();
    int cyc; logic [N-1:0] g; logic [W-1:0] r; logic rv;
    do_reset();
    req = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    req = 4'b0100;
    wait_gnt(40, cyc, g, r, rv);
    checks++;
    if (g !== 4'b0001 || r !== 12'h735) begin
      errors++;
      $display("FAIL drop_owner: gnt=%b rand=%h required 0001/735", g, r);
    end
    wait_gnt(40, cyc, g, r, rv);
    checks++;
    if (g !== 4'b0100 || cyc !== 14 || r !== 12'h278) begin
      errors++;
      $display("FAIL drop_next: gnt=%b cyc=%0d rand=%h required 0100/14/278", g, cyc, r);
    end
    req = '0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_reset_mid_gen();
    int cyc; logic [N-1:0] g; logic [W-1:0] r; logic rv;
    do_reset();
    req = 4'b0001;
    wait_gnt(40, cyc, g, r, rv);
    req = 4'b0010;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || rand_valid !== 1'b0 || busy !== 1'b0 || rand_out !== 12'h000) begin
      errors++;
      $display("FAIL midgen_reset: gnt=%b rv=%b busy=%b rand=%h required 0000/0/0/000",
               gnt, rand_valid, busy, rand_out);
    end
    req = '0;
    @(negedge clk); rst = 1'b0;
    wait_gnt(20, cyc, g, r, rv);
    checks++;
    if (cyc !== -1) begin
      errors++;
      $display("FAIL midgen_no_grant: gnt=%b at cycle %0d required no grant", g, cyc);
    end
    req = 4'b0001;
    wait_gnt(40, cyc, g, r, rv);
    checks++;
    if (g !== 4'b0001 || r !== 12'h735) begin
      errors++;
      $display("FAIL midgen_restart: gnt=%b rand=%h required 0001/735", g, r);
    end
    req = '0;
    @(posedge clk); @(posedge clk);
  endtask

`ifdef RNG_RESEED_EN
  task automatic test_reseed();
    int cyc; logic [N-1:0] g; logic [W-1:0] r; logic rv;
    do_reset();
    seed_load = 1'b1; seed_val = 16'hFFFF;
    @(posedge clk); #1;
    seed_load = 1'b0;
    req = 4'b0010;
    wait_gnt(40, cyc, g, r, rv);
    checks++;
    if (g !== 4'b0010 || r !== 12'hFFF) begin
      errors++;
      $display("FAIL reseed_ffff: gnt=%b rand=%h required 0010/fff", g, r);
    end
    req = '0;
    @(posedge clk); @(posedge clk); #1;
    seed_load = 1'b1; seed_val = 16'h0000;
    @(posedge clk); #1;
    seed_load = 1'b0;
    req = 4'b0001;
    wait_gnt(40, cyc, g, r, rv);
    checks++;
    if (g !== 4'b0001 || r !== 12'h735) begin
      errors++;
      $display("FAIL reseed_zero: gnt=%b rand=%h required 0001/735", g, r);
    end
    req = '0;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_seed_and_req();
    int cyc; logic [N-1:0] g; logic [W-1:0] r; logic rv;
    do_reset();
    seed_load = 1'b1; seed_val = 16'hFFFF; req = 4'b0001;
    @(posedge clk); #1;
    seed_load = 1'b0;
    wait_gnt(40, cyc, g, r, rv);
    cyc = cyc + 1;
    checks++;
    if (cyc !== 14 || g !== 4'b0001 || r !== 12'hFFF) begin
      errors++;
      $display("FAIL seed_req_same: cyc=%0d gnt=%b rand=%h required 14/0001/fff", cyc, g, r);
    end
    req = '0;
    @(posedge clk); @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_during_gen();
    test_reset_mid_gen();
`ifdef RNG_RESEED_EN
    test_reseed();
    test_seed_and_req();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
